// File: rtl/seg_scan_capture.sv
// Multiplexed 7-segment bus monitor.
// Recovers per-digit code and decimal point with settle and multi-scan stability.
module seg_scan_capture #(
  parameter int DIGITS       = 4,
  parameter int SETTLE_CYC   = 8,
  parameter int STABLE_SCANS = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [7:0]            seg_in,
  input  logic [DIGITS-1:0]     an_in,
  output logic [5*DIGITS-1:0]   digit_codes,
  output logic [DIGITS-1:0]     dp_out,
  output logic [DIGITS-1:0]     digit_err,
  output logic                  update,
  output logic                  frame_valid
);

  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int CW = 4;
  localparam int SW = 8;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETTLE,
    S_CAPTURE,
    S_RELEASE
  } state_t;

  state_t                   r_state;
  logic [7:0]               r_seg_m;
  logic [7:0]               r_seg_s;
  logic [DIGITS-1:0]        r_an_m;
  logic [DIGITS-1:0]        r_an_s;
  logic [IW-1:0]            r_idx;
  logic [7:0]               r_pat;
  logic [SW-1:0]            r_set_cnt;

  logic [DIGITS-1:0][4:0]   r_cand_code;
  logic [DIGITS-1:0]        r_cand_dp;
  logic [DIGITS-1:0]        r_cand_err;
  logic [DIGITS-1:0][CW-1:0] r_cnt;
  logic [DIGITS-1:0][4:0]   r_code;
  logic [DIGITS-1:0]        r_dp;
  logic [DIGITS-1:0]        r_err;
  logic [DIGITS-1:0]        r_mask;
  logic                     r_update;
  logic                     r_fv;

  logic [DIGITS-1:0]        w_oh;
  logic                     w_single;
  logic [IW-1:0]            w_idx;
  logic                     w_hold;
  logic [5:0]               w_dec;
  logic [4:0]               w_code;
  logic                     w_dp;
  logic                     w_err;
  logic                     w_same;
  logic [CW-1:0]            w_cnt_nx;
  logic                     w_cap_en;
  logic                     w_commit;
  logic                     w_changed;
  logic [DIGITS-1:0]        w_mask_nx;
  logic                     w_full;

  function automatic logic [5:0] f_decode(input logic [6:0] p);
    logic [5:0] r;
    case (p)
      7'h7E:   r = {1'b0, 5'h00};
      7'h30:   r = {1'b0, 5'h01};
      7'h6D:   r = {1'b0, 5'h02};
      7'h79:   r = {1'b0, 5'h03};
      7'h33:   r = {1'b0, 5'h04};
      7'h5B:   r = {1'b0, 5'h05};
      7'h5F:   r = {1'b0, 5'h06};
      7'h70:   r = {1'b0, 5'h07};
      7'h7F:   r = {1'b0, 5'h08};
      7'h7B:   r = {1'b0, 5'h09};
      7'h77:   r = {1'b0, 5'h0A};
      7'h1F:   r = {1'b0, 5'h0B};
      7'h4E:   r = {1'b0, 5'h0C};
      7'h3D:   r = {1'b0, 5'h0D};
      7'h4F:   r = {1'b0, 5'h0E};
      7'h47:   r = {1'b0, 5'h0F};
      7'h00:   r = {1'b0, 5'h10};
      default: r = {1'b1, 5'h1F};
    endcase
    return r;
  endfunction

  // Exactly one active-low anode: nonzero one-hot test on the inverted lines.
  always_comb begin
    w_oh     = ~r_an_s;
    w_single = (w_oh != '0) &&
               ((w_oh & (w_oh - DIGITS'(1))) == '0);
    w_idx    = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (w_oh[i]) w_idx = IW'(i);
    end
  end

  assign w_hold = w_single && (w_idx == r_idx) && (r_seg_s == r_pat);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_seg_m   <= '0;
      r_seg_s   <= '0;
      r_an_m    <= '1;
      r_an_s    <= '1;
      r_state   <= S_IDLE;
      r_idx     <= '0;
      r_pat     <= '0;
      r_set_cnt <= '0;
    end else begin
      r_seg_m <= seg_in;
      r_seg_s <= r_seg_m;
      r_an_m  <= an_in;
      r_an_s  <= r_an_m;
      unique case (r_state)
        S_IDLE: begin
          if (w_single) begin
            r_idx     <= w_idx;
            r_pat     <= r_seg_s;
            r_set_cnt <= '0;
            r_state   <= S_SETTLE;
          end
        end
        S_SETTLE: begin
          if (!w_hold) begin
            r_state <= S_IDLE;
          end else if (r_set_cnt == SW'(SETTLE_CYC - 1)) begin
            r_state <= S_CAPTURE;
          end else begin
            r_set_cnt <= r_set_cnt + SW'(1);
          end
        end
        S_CAPTURE: r_state <= S_RELEASE;
        S_RELEASE: begin
          if (!w_single || (w_idx != r_idx)) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign w_dec    = f_decode(r_pat[7:1]);
  assign w_code   = w_dec[4:0];
  assign w_err    = w_dec[5];
  assign w_dp     = r_pat[0];
  assign w_cap_en = (r_state == S_CAPTURE);

  assign w_same = (w_code == r_cand_code[r_idx]) &&
                  (w_dp == r_cand_dp[r_idx]) &&
                  (w_err == r_cand_err[r_idx]);

  always_comb begin
    w_cnt_nx = CW'(1);
    if (w_same) begin
      if (r_cnt[r_idx] == CW'(STABLE_SCANS)) w_cnt_nx = r_cnt[r_idx];
      else w_cnt_nx = r_cnt[r_idx] + CW'(1);
    end
  end

  assign w_commit  = w_cap_en && (w_cnt_nx == CW'(STABLE_SCANS));
  assign w_changed = (w_code != r_code[r_idx]) ||
                     (w_dp != r_dp[r_idx]) ||
                     (w_err != r_err[r_idx]);
  assign w_mask_nx = r_mask | (DIGITS'(1) << r_idx);
  assign w_full    = (w_mask_nx == '1);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cand_code <= {DIGITS{5'h10}};
      r_cand_dp   <= '0;
      r_cand_err  <= '0;
      r_cnt       <= '0;
      r_code      <= {DIGITS{5'h10}};
      r_dp        <= '0;
      r_err       <= '0;
      r_mask      <= '0;
      r_update    <= 1'b0;
      r_fv        <= 1'b0;
    end else begin
      r_update <= 1'b0;
      r_fv     <= 1'b0;
      if (w_cap_en) begin
        r_cand_code[r_idx] <= w_code;
        r_cand_dp[r_idx]   <= w_dp;
        r_cand_err[r_idx]  <= w_err;
        r_cnt[r_idx]       <= w_cnt_nx;
        if (w_commit) begin
          r_code[r_idx] <= w_code;
          r_dp[r_idx]   <= w_dp;
          r_err[r_idx]  <= w_err;
          r_update      <= w_changed;
          // Completing digit closes the frame and does not seed the next one.
          if (w_full) begin
            r_fv   <= 1'b1;
            r_mask <= '0;
          end else begin
            r_mask <= w_mask_nx;
          end
        end
      end
    end
  end

  assign digit_codes = r_code;
  assign dp_out      = r_dp;
  assign digit_err   = r_err;
  assign update      = r_update;
  assign frame_valid = r_fv;

endmodule

// File: doc/seg_scan_capture.md
Name: seg_scan_capture

Overview:
- Receive-side counterpart of the binary-to-segment decoder: monitors a multiplexed 7-segment display bus (segment lines plus active-low digit anodes) and recovers the 5-bit digit code and decimal point for each digit.
- Used in test fixtures and loopback checks to read back what the display driver is emitting, and by the panel-sniffer path.
- Decodes segment patterns with the team's standard inverse table, filters glitches and requires multi-scan stability before committing a digit.

Parameters:
- DIGITS, 4, number of multiplexed digits (anode lines).
- SETTLE_CYC, 8, cycles a single anode plus segment pattern must hold unchanged before it is captured (range 1..255).
- STABLE_SCANS, 2, consecutive identical captures of one digit required before its output updates (range 1..15).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  synchronous reset, active-low.
- seg_in  in  8  segment lines, active-high; bit7=a, bit6=b, ... bit1=g, bit0=dp; asynchronous to clk.
- an_in  in  DIGITS  digit anodes, active-low one-hot; asynchronous to clk.
- digit_codes  out  5*DIGITS  committed code per digit; digit i occupies bits [5i+4:5i].
- dp_out  out  DIGITS  committed decimal point per digit.
- digit_err  out  DIGITS  1 = last committed pattern for that digit was not in the table.
- update  out  1  one-cycle pulse when any committed value changes.
- frame_valid  out  1  one-cycle pulse when every digit has committed at least once since the previous pulse.

Behaviour:
- Reset (rst_n low at a clk edge) clears all state:
  - digit_codes = 5'h10 for every digit.
  - dp_out = 0, digit_err = 0, update = 0, frame_valid = 0.
  - FSM goes to IDLE; settle counter, stability counters and the frame mask are cleared.
  - Reset asserted mid-settle or mid-capture discards the partial capture.
- Synchronisation: seg_in and an_in each pass through a 2-flop synchroniser. All logic below uses the synchronised values.
- Anode qualification: "single" means exactly one bit of ~an_sync is set; its index is the active digit.
- FSM:
  - IDLE: wait for single anode; on entry to a single anode, latch index and pattern, clear settle counter, go to SETTLE.
  - SETTLE: counter increments each cycle while index and pattern match the latched values.
    - Any mismatch or loss of single anode returns to IDLE in the same cycle, without capturing.
    - Counter reaching SETTLE_CYC-1 goes to CAPTURE.
  - CAPTURE: one cycle; decode and run stability logic, then go to RELEASE.
  - RELEASE: hold until the anode is no longer single or the index changes, then go to IDLE. Only one capture per anode dwell.
- Decode uses pattern[7:1] only (dp ignored):
  - 0x7E->0, 0x30->1, 0x6D->2, 0x79->3, 0x33->4, 0x5B->5, 0x5F->6, 0x70->7, 0x7F->8, 0x7B->9.
  - 0x77->10, 0x1F->11, 0x4E->12, 0x3D->13, 0x4F->14, 0x47->15, 0x00->16 (blank).
  - Any other value -> code 5'h1F with err=1.
- Stability (per digit):
  - Each digit keeps a candidate {code, dp, err} and a match counter.
  - If the capture equals the candidate, the counter increments, saturating at STABLE_SCANS.
  - Otherwise the candidate is replaced by the capture and the counter is set to 1.
  - When the counter reaches STABLE_SCANS, the candidate is committed to the outputs one cycle after CAPTURE.
  - update pulses in that same cycle only if the committed value differs from the previous one.
- Frame mask:
  - The mask bit for the digit sets on each commit, whether or not the value changed.
  - When all DIGITS bits are set, frame_valid pulses for one cycle and the mask clears in that same cycle.
- If a commit for the last missing digit and a mask clear coincide, the pulse fires and that digit's bit starts the new frame cleared.
- Latency: from the anode becoming stable at the pins to the output commit is 2 + SETTLE_CYC + 2 cycles, repeated over STABLE_SCANS scans.
- Counters are sized to their parameter range; no wrap-around is possible.

Test Plan:
- Reset then idle with an_in=4'hF -> digit_codes=20'h84210 (all 5'h10), update=0, frame_valid=0 indefinitely.
- Drive a scan with 40 cycles per digit, anodes 0..3 showing seg 8'h60, 8'hDA, 8'hF2, 8'h67, for 2 full scans -> digit_codes = {4,3,2,1}, dp_out=4'b1000, digit_err=0, one frame_valid pulse per full scan after the second scan.
- Glitch: anode 0 holds 8'hFC for only 5 cycles (less than SETTLE_CYC) -> no capture, digit 0 unchanged.
- Unstable digit: digit 1 alternates 8'hFC and 8'h60 on successive scans -> never commits; digit_codes[9:5] stays 5'h10 and no update pulse.
- Invalid pattern 8'h02 (only g lit) held on digit 2 for 2 scans -> code 5'h1F and digit_err[2]=1; then 8'h00 for 2 scans -> code 5'h10 and err clears.
- Two anodes low simultaneously (an_in=4'b1100) for 100 cycles -> no capture. Deassert rst_n during SETTLE -> all outputs return to reset values on the next edge.
